// File: rtl/magsq_integrate.sv
// magsq_integrate: sums magnitude-squared samples over a window of len beats and emits one scaled result per window.
// Ports: clk, reset_n (sync, active-low), clear (sync flush), len (window length, 0 = 2^MAX_LEN_LOG2),
//   shift (result right shift, clamped to MAX_LEN_LOG2), i_t* (AXI-Stream samples in), o_t* (AXI-Stream results out).
// Build option: define MAGSQ_INTEGRATE_SAT_EN to saturate results that do not fit in 2*WIDTH bits (default wraps).
module magsq_integrate #(
  parameter int WIDTH = 16,
  parameter int MAX_LEN_LOG2 = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic [MAX_LEN_LOG2-1:0]   len,
  input  logic [5:0]                shift,
  input  logic [2*WIDTH-1:0]        i_tdata,
  input  logic                      i_tlast,
  input  logic                      i_tvalid,
  output logic                      i_tready,
  output logic [2*WIDTH-1:0]        o_tdata,
  output logic                      o_tlast,
  output logic                      o_tvalid,
  input  logic                      o_tready
);
  localparam int DW = 2 * WIDTH;
  localparam int AW = DW + MAX_LEN_LOG2;
  logic [AW-1:0] acc, sum;
  logic [MAX_LEN_LOG2-1:0] cnt;
  logic [MAX_LEN_LOG2:0] win_len, cur_len;
  logic [5:0] sh;
  logic beat, close_win;
  logic [DW-1:0] res;
  assign i_tready = !o_tvalid || o_tready;
  assign beat = i_tvalid && i_tready;
  // The first beat of a window uses the live len; later beats use the latched copy.
  assign cur_len = (cnt == '0) ? ((len == '0) ? {1'b1, {MAX_LEN_LOG2{1'b0}}} : {1'b0, len}) : win_len;
  assign close_win = i_tlast || ({1'b0, cnt} == cur_len - (MAX_LEN_LOG2 + 1)'(1));
  assign sh = (shift > 6'(MAX_LEN_LOG2)) ? 6'(MAX_LEN_LOG2) : shift;
  assign sum = acc + AW'(i_tdata);
`ifdef MAGSQ_INTEGRATE_SAT_EN
  logic [AW-1:0] shifted;
  assign shifted = sum >> sh;
  assign res = (|shifted[AW-1:DW]) ? '1 : shifted[DW-1:0];
`else
  assign res = DW'(sum >> sh);
`endif
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      acc <= '0;
      cnt <= '0;
      win_len <= '0;
      o_tdata <= '0;
      o_tlast <= 1'b0;
      o_tvalid <= 1'b0;
    end else begin
      if (o_tvalid && o_tready) o_tvalid <= 1'b0;
      if (beat) begin
        if (cnt == '0) win_len <= cur_len;
        if (close_win) begin
          // A close during a drain overwrites the register, so valid stays high with no bubble.
          acc <= '0;
          cnt <= '0;
          o_tdata <= res;
          o_tlast <= i_tlast;
          o_tvalid <= 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule
